harris_corner_collector: RTL and testbench

//  Consumer end of the Harris detector output stream (valid/pixel/corner beats, raster order).

---
 rtl/harris_corner_collector.sv | 124 ++++++++++++
 tb/tb_harris_corner_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/harris_corner_collector.sv
// harris_corner_collector: tracks raster position of detector beats and queues corner (x,y) in a FIFO.
// Define HARRIS_NMS_ROW_EN to suppress corners closer than MIN_DIST to the previous one in the same row.
module harris_corner_collector #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 464,
  parameter int COORD_WIDTH  = 10,
  parameter int FIFO_DEPTH   = 64,
  parameter int MIN_DIST     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_pixel,
  input  logic                   in_corner,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_WIDTH-1:0] out_x,
  output logic [COORD_WIDTH-1:0] out_y,
  output logic [15:0]            corner_count,
  output logic                   overflow,
  output logic                   frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2;
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(IMAGE_HEIGHT - 1);

  logic [1:0] state;
  logic [COORD_WIDTH-1:0] x, y, cx, cy, hold_x, hold_y;
  logic [COORD_WIDTH-1:0] mem_x [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_y [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, rd_next, wr_base, level;
  logic [15:0] cnt_base;
  logic idle_start, abort, beat, clear, row_end, frame_end, empty, full, pop, cand, push, suppress;
  logic unused_ok;

  assign idle_start = state == IDLE & frame_start;
  assign abort      = state == COLLECT & frame_start;
  assign beat       = state == COLLECT & in_valid;
  assign clear      = idle_start | abort;
  // An aborting beat is pixel (0,0) of the restarted frame.
  assign cx         = abort ? '0 : x;
  assign cy         = abort ? '0 : y;
  assign row_end    = cx == X_LAST;
  assign frame_end  = row_end & cy == Y_LAST;
  assign level      = wr_ptr - rd_ptr;
  assign empty      = level == '0;
  assign full       = level == (AW + 1)'(FIFO_DEPTH);
  assign pop        = !empty & out_ready;
  assign rd_next    = rd_ptr + (AW + 1)'(pop);
  assign wr_base    = abort ? rd_next : wr_ptr;
  assign cand       = beat & in_corner & !suppress;
  assign push       = cand & (abort | !full | pop);
  assign cnt_base   = clear ? '0 : corner_count;
  assign out_valid  = !empty;
  assign out_x      = empty ? hold_x : mem_x[rd_ptr[AW-1:0]];
  assign out_y      = empty ? hold_y : mem_y[rd_ptr[AW-1:0]];
  assign unused_ok  = ^{in_pixel, 32'(MIN_DIST)};

`ifdef HARRIS_NMS_ROW_EN
  logic nms_valid;
  logic [COORD_WIDTH-1:0] nms_x;
  // Memory is dropped at row end, so a live entry always belongs to the current row.
  assign suppress = nms_valid & !abort & (cx - nms_x) < COORD_WIDTH'(MIN_DIST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nms_valid <= 1'b0;
      nms_x     <= '0;
    end else if (idle_start | (beat & row_end)) nms_valid <= 1'b0;
    else if (cand) begin
      nms_valid <= 1'b1;
      nms_x     <= cx;
    end else if (abort) nms_valid <= 1'b0;
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk)
    if (push) begin
      mem_x[wr_base[AW-1:0]] <= cx;
      mem_y[wr_base[AW-1:0]] <= cy;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      hold_x       <= '0;
      hold_y       <= '0;
      corner_count <= '0;
      overflow     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      rd_ptr       <= rd_next;
      wr_ptr       <= wr_base + (AW + 1)'(push);
      corner_count <= cnt_base + 16'(cand & ~&cnt_base);
      overflow     <= !clear & (overflow | (cand & !push));
      if (pop) begin
        hold_x <= mem_x[rd_ptr[AW-1:0]];
        hold_y <= mem_y[rd_ptr[AW-1:0]];
      end
      if (idle_start) begin
        state <= COLLECT;
        x     <= '0;
        y     <= '0;
      end else if (beat) begin
        x <= row_end ? '0 : cx + 1'b1;
        y <= row_end ? (frame_end ? '0 : cy + 1'b1) : cy;
        if (frame_end) state <= DRAIN;
      end else if (abort) begin
        x <= '0;
        y <= '0;
      end else if (state == DRAIN & empty) begin
        state      <= IDLE;
        frame_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_harris_corner_collector.sv
// tb_harris_corner_collector: directed checks of the corner collector on an 8x4 frame with a 4-entry FIFO.
module tb_harris_corner_collector;
  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, in_valid = 1'b0, in_corner = 1'b0, out_ready = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic out_valid, overflow, frame_done;
  logic [9:0] out_x, out_y;
  logic [15:0] corner_count;
  logic [19:0] q[$];
  int checks = 0, errors = 0, done_cnt = 0;

  harris_corner_collector #(
    .DATA_WIDTH(8), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .COORD_WIDTH(10), .FIFO_DEPTH(4), .MIN_DIST(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_corner(in_corner), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .corner_count(corner_count), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back({out_x, out_y});
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic beats(input logic [31:0] mask);
    for (int i = 0; i < 32; i++) begin
      in_valid  = 1'b1;
      in_corner = mask[i];
      in_pixel  = mask[i] ? 8'hFF : 8'h00;
      step();
    end
    in_valid  = 1'b0;
    in_corner = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int prev = done_cnt;
    for (int i = 0; i < 100 && done_cnt == prev; i++) step();
    check(tag, done_cnt, prev + 1);
  endtask

  initial begin
    int d;
    logic [31:0] m;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_x", out_x, 0);
    check("rst out_y", out_y, 0);
    check("rst count", corner_count, 0);
    check("rst overflow", overflow, 0);
    check("rst frame_done", frame_done, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // basic frame
    out_ready = 1'b1;
    q.delete();
    d = done_cnt;
    start();
    m = 32'h0;
    m[10] = 1'b1;
    m[21] = 1'b1;
    beats(m);
    check("t1 no early done", done_cnt, d);
    wait_done("t1 done");
    check("t1 n", q.size(), 2);
    check("t1 c0", q[0], {10'd2, 10'd1});
    check("t1 c1", q[1], {10'd5, 10'd2});
    check("t1 count", corner_count, 2);
    step();
    check("t1 single done", done_cnt, d + 1);

    // backpressure and overflow
    out_ready = 1'b0;
    q.delete();
    d = done_cnt;
    start();
    beats(32'h0000_003F);
    step();
    step();
    step();
    check("t2 overflow", overflow, 1);
    check("t2 count", corner_count, 6);
    check("t2 no done", done_cnt, d);
    check("t2 head valid", out_valid, 1);
    check("t2 head xy", {out_x, out_y}, {10'd0, 10'd0});
    out_ready = 1'b1;
    wait_done("t2 done");
    check("t2 n", q.size(), 4);
    check("t2 c0", q[0], {10'd0, 10'd0});
    check("t2 c1", q[1], {10'd1, 10'd0});
    check("t2 c2", q[2], {10'd2, 10'd0});
    check("t2 c3", q[3], {10'd3, 10'd0});
    check("t2 sticky", overflow, 1);
    check("t2 hold x", out_x, 3);

    // gaps and row wrap; corner flag on gap cycles must be ignored
    q.delete();
    start();
    check("t3 overflow cleared", overflow, 0);
    for (int i = 0; i < 64; i++) begin
      in_valid  = (i % 2) == 0;
      in_corner = (i % 2) == 1 || i / 2 == 7 || i / 2 == 8;
      step();
    end
    in_valid  = 1'b0;
    in_corner = 1'b0;
    wait_done("t3 done");
    check("t3 n", q.size(), 2);
    check("t3 c0", q[0], {10'd7, 10'd0});
    check("t3 c1", q[1], {10'd0, 10'd1});
    check("t3 count", corner_count, 2);

    // reset mid-frame
    out_ready = 1'b0;
    q.delete();
    start();
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_corner = i == 2;
      step();
    end
    in_valid  = 1'b0;
    in_corner = 1'b0;
    check("t4 queued", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t4 out_valid", out_valid, 0);
    check("t4 out_xy", {out_x, out_y}, 20'd0);
    check("t4 count", corner_count, 0);
    check("t4 overflow", overflow, 0);
    check("t4 frame_done", frame_done, 0);
    step();
    rst_n = 1'b1;
    in_valid  = 1'b1;
    in_corner = 1'b1;
    step();
    in_valid  = 1'b0;
    in_corner = 1'b0;
    check("t4 idle ignores beats", out_valid, 0);
    out_ready = 1'b1;
    start();
    beats(32'h0000_0001);
    wait_done("t4 done");
    check("t4 n", q.size(), 1);
    check("t4 c0", q[0], {10'd0, 10'd0});

    // abort with queued corners
    out_ready = 1'b0;
    q.delete();
    start();
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      in_corner = i == 2 || i == 5;
      step();
    end
    check("t5 count before", corner_count, 2);
    frame_start = 1'b1;
    in_valid    = 1'b1;
    in_corner   = 1'b0;
    step();
    frame_start = 1'b0;
    check("t5 flushed", out_valid, 0);
    check("t5 count cleared", corner_count, 0);
    for (int i = 1; i < 32; i++) begin
      in_valid  = 1'b1;
      in_corner = i == 3;
      step();
      if (i == 3) check("t5 head", {out_x, out_y}, {10'd3, 10'd0});
    end
    in_valid  = 1'b0;
    in_corner = 1'b0;
    out_ready = 1'b1;
    wait_done("t5 done");
    check("t5 n", q.size(), 1);
    check("t5 c0", q[0], {10'd3, 10'd0});
    check("t5 count", corner_count, 1);

    // same-row suppression
    q.delete();
    start();
    m = 32'h0;
    m[11] = 1'b1;
    m[12] = 1'b1;
    m[15] = 1'b1;
    beats(m);
    wait_done("t6 done");
    check("t6 c0", q[0], {10'd3, 10'd1});
`ifdef HARRIS_NMS_ROW_EN
    check("t6 n", q.size(), 2);
    check("t6 c1", q[1], {10'd7, 10'd1});
    check("t6 count", corner_count, 2);
`else
    check("t6 n", q.size(), 3);
    check("t6 c1", q[1], {10'd4, 10'd1});
    check("t6 c2", q[2], {10'd7, 10'd1});
    check("t6 count", corner_count, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
